// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between the fetch (IF) and the
//               load/store (ME) requesters. ME has priority. Define
//               ARB_FAIRNESS_EN to bound IF starvation to STARVE_MAX ME grants.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic [DW-1:0]   if_rdata,
    output logic            if_ack,
    input  logic            me_req,
    input  logic            me_wr,
    input  logic [DW/8-1:0] me_wmask,
    input  logic [AW-1:0]   me_addr,
    input  logic [DW-1:0]   me_wdata,
    output logic [DW-1:0]   me_rdata,
    output logic            me_ack,
    output logic            mem_req,
    output logic            mem_wr,
    output logic [DW/8-1:0] mem_wmask,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ready,
    output logic            pause_if,
    output logic            pause_me
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_ME = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state;
    logic   force_if;
    logic   grant_if;
    logic   grant_me;

`ifdef ARB_FAIRNESS_EN
    localparam int            CW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt;

    // IF overrides ME priority once it has waited through STARVE_MAX ME grants
    assign force_if = if_req && (starve_cnt == STARVE_LIM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (grant_if) begin
            starve_cnt <= '0;
        end else if (grant_me && if_req && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end
`else
    assign force_if = 1'b0;
`endif

    assign grant_me = (state == IDLE) && me_req && !force_if;
    assign grant_if = (state == IDLE) && if_req && (force_if || !me_req);

    assign pause_if = if_req & ~if_ack;
    assign pause_me = me_req & ~me_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wmask <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            me_rdata  <= '0;
            if_ack    <= 1'b0;
            me_ack    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_me) begin
                        state     <= GNT_ME;
                        mem_req   <= 1'b1;
                        mem_wr    <= me_wr;
                        mem_wmask <= me_wmask;
                        mem_addr  <= me_addr;
                        mem_wdata <= me_wdata;
                    end else if (grant_if) begin
                        state     <= GNT_IF;
                        mem_req   <= 1'b1;
                        mem_wr    <= 1'b0;
                        mem_wmask <= '0;
                        mem_addr  <= if_addr;
                    end
                end
                GNT_IF: begin
                    if (mem_ready) begin
                        state    <= DONE;
                        mem_req  <= 1'b0;
                        if_rdata <= mem_rdata;
                        if_ack   <= 1'b1;
                    end
                end
                GNT_ME: begin
                    if (mem_ready) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        // stores complete without disturbing the last load value
                        if (!mem_wr) begin
                            me_rdata <= mem_rdata;
                        end
                        me_ack  <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    if_ack <= 1'b0;
                    me_ack <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter with random requesters,
//               a random-latency memory and a transaction-level reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int MW         = DW / 8;
    localparam int STARVE_MAX = 4;
`ifdef ARB_FAIRNESS_EN
    localparam int EXP_ME_BEFORE_IF = STARVE_MAX;
`else
    localparam int EXP_ME_BEFORE_IF = 10;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          me_req;
    logic          me_wr;
    logic [MW-1:0] me_wmask;
    logic [AW-1:0] me_addr;
    logic [DW-1:0] me_wdata;
    logic [DW-1:0] me_rdata;
    logic          me_ack;
    logic          mem_req;
    logic          mem_wr;
    logic [MW-1:0] mem_wmask;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          pause_if;
    logic          pause_me;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .me_req(me_req), .me_wr(me_wr), .me_wmask(me_wmask), .me_addr(me_addr),
        .me_wdata(me_wdata), .me_rdata(me_rdata), .me_ack(me_ack),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pause_if(pause_if), .pause_me(pause_me)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // IF space has bit 12 set and is read-only; ME space is 64 words below 0x100
    logic [31:0] mem_arr [64];
    logic [31:0] ref_mem [64];
    logic [31:0] if_exp_q [$];
    logic [31:0] me_exp_q [$];

    logic [31:0] if_txn_addr;
    logic [31:0] me_txn_addr;
    logic        me_txn_wr;
    logic [31:0] me_txn_wdata;
    logic [3:0]  me_txn_wmask;
    logic [31:0] me_last;
    bit          stall;
    bit          armed;
    int          me_ack_cnt;
    int          first_if_me_cnt;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] if_word(logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    task automatic wait_if_ack();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (if_ack) begin
                got = 1'b1;
                break;
            end
        end
        chk("if_ack_seen", got, 1);
        #1;
    endtask

    task automatic if_issue_wait();
        if_addr     = 32'h1000 | (32'($urandom_range(0, 1023)) << 2);
        if_req      = 1'b1;
        if_txn_addr = if_addr;
        if_exp_q.push_back(if_word(if_addr));
        wait_if_ack();
    endtask

    task automatic me_issue_wait();
        bit got;
        bit scrambled;
        int idx;
        me_addr   = 32'($urandom_range(0, 63)) << 2;
        me_wr     = 1'($urandom_range(0, 1));
        me_wdata  = $urandom;
        me_wmask  = 4'($urandom_range(0, 15));
        me_req    = 1'b1;
        me_txn_addr  = me_addr;
        me_txn_wr    = me_wr;
        me_txn_wdata = me_wdata;
        me_txn_wmask = me_wmask;
        idx = int'(me_addr[7:2]);
        if (me_wr) ref_mem[idx] = merge(ref_mem[idx], me_wdata, me_wmask);
        else       me_last = ref_mem[idx];
        me_exp_q.push_back(me_last);
        got = 1'b0;
        scrambled = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (me_ack) begin
                got = 1'b1;
                break;
            end
            // once granted, changing the request fields must not affect the access
            if (mem_req && !mem_addr[12] && !scrambled && ($urandom_range(0, 1) == 1)) begin
                #1;
                me_addr   = 32'($urandom_range(0, 63)) << 2;
                me_wdata  = $urandom;
                me_wmask  = 4'($urandom_range(0, 15));
                me_wr     = ~me_wr;
                scrambled = 1'b1;
            end
        end
        chk("me_ack_seen", got, 1);
        #1;
    endtask

    task automatic if_run(int n, int maxgap);
        int gap;
        for (int i = 0; i < n; i++) begin
            if_issue_wait();
            gap = int'($urandom_range(0, maxgap));
            if (gap > 0 || i == n - 1) begin
                if_req = 1'b0;
                repeat (gap) @(negedge clk);
                if (gap > 0) #1;
            end
        end
    endtask

    task automatic me_run(int n, int maxgap);
        int gap;
        for (int i = 0; i < n; i++) begin
            me_issue_wait();
            gap = int'($urandom_range(0, maxgap));
            if (gap > 0 || i == n - 1) begin
                me_req = 1'b0;
                repeat (gap) @(negedge clk);
                if (gap > 0) #1;
            end
        end
    endtask

    task automatic check_reset_state(string tag);
        chk({tag, "_mem_req"},   mem_req, 0);
        chk({tag, "_mem_wr"},    mem_wr, 0);
        chk({tag, "_mem_wmask"}, mem_wmask, 0);
        chk({tag, "_mem_addr"},  mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_if_rdata"},  if_rdata, 0);
        chk({tag, "_me_rdata"},  me_rdata, 0);
        chk({tag, "_if_ack"},    if_ack, 0);
        chk({tag, "_me_ack"},    me_ack, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #1;
        if_req = 1'b0;
        me_req = 1'b0;
        rst    = 1'b0;
        #1;
        check_reset_state("midrst");
        @(negedge clk);
        #2;
        rst     = 1'b1;
        me_last = '0;
        @(negedge clk);
        #1;
    endtask

    // Memory device: random wait states, noise on mem_ready while no request is active
    initial begin : responder
        bit          active;
        int          wait_left;
        logic [31:0] cap_addr;
        logic [31:0] cap_wdata;
        logic [3:0]  cap_wmask;
        logic        cap_wr;
        active    = 1'b0;
        wait_left = 0;
        cap_addr  = '0;
        cap_wdata = '0;
        cap_wmask = '0;
        cap_wr    = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                active    = 1'b0;
                mem_ready = 1'b0;
                continue;
            end
            if (mem_req) begin
                if (!active) begin
                    active    = 1'b1;
                    cap_addr  = mem_addr;
                    cap_wdata = mem_wdata;
                    cap_wmask = mem_wmask;
                    cap_wr    = mem_wr;
                    wait_left = int'($urandom_range(0, 3));
                end else begin
                    chk("hold_addr",  mem_addr,  cap_addr);
                    chk("hold_wr",    mem_wr,    cap_wr);
                    chk("hold_wmask", mem_wmask, cap_wmask);
                    chk("hold_wdata", mem_wdata, cap_wdata);
                end
                if (!stall && wait_left == 0) begin
                    mem_ready = 1'b1;
                    if (cap_addr[12]) begin
                        mem_rdata = if_word(cap_addr);
                    end else begin
                        mem_rdata = mem_arr[cap_addr[7:2]];
                        if (cap_wr) mem_arr[cap_addr[7:2]] = merge(mem_arr[cap_addr[7:2]], cap_wdata, cap_wmask);
                    end
                    active = 1'b0;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = $urandom;
                    if (wait_left > 0) wait_left--;
                end
            end else begin
                active    = 1'b0;
                mem_ready = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
        end
    end

    // Monitor: arbitration, handshake timing and scoreboard of returned data
    initial begin : monitor
        bit          prev_req;
        bit          prev_ack;
        bit          prev_me_owner;
        bit          exp_ack;
        bit          exp_req;
        bit          exp_me;
        int          starve;
        logic [31:0] exp_data;
        prev_req      = 1'b0;
        prev_ack      = 1'b0;
        prev_me_owner = 1'b0;
        starve        = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_req = 1'b0;
                prev_ack = 1'b0;
                starve   = 0;
                continue;
            end
            exp_ack = prev_req && mem_ready;
            chk("ack_timing", if_ack | me_ack, exp_ack);
            chk("ack_exclusive", if_ack & me_ack, 0);
            if (exp_ack) chk("ack_to_me", me_ack, prev_me_owner);
            if (if_ack) begin
                if (if_exp_q.size() == 0) begin
                    chk("if_ack_unexpected", if_ack, 0);
                end else begin
                    exp_data = if_exp_q.pop_front();
                    chk("if_rdata", if_rdata, exp_data);
                end
                if (armed) begin
                    first_if_me_cnt = me_ack_cnt;
                    armed = 1'b0;
                end
            end
            if (me_ack) begin
                me_ack_cnt++;
                if (me_exp_q.size() == 0) begin
                    chk("me_ack_unexpected", me_ack, 0);
                end else begin
                    exp_data = me_exp_q.pop_front();
                    chk("me_rdata", me_rdata, exp_data);
                end
            end
            if (prev_req)      exp_req = !mem_ready;
            else if (prev_ack) exp_req = 1'b0;
            else               exp_req = if_req | me_req;
            chk("mem_req", mem_req, exp_req);
            if (!prev_req && !prev_ack && (if_req || me_req)) begin
`ifdef ARB_FAIRNESS_EN
                exp_me = me_req && !(if_req && starve == STARVE_MAX);
                if (!exp_me)                          starve = 0;
                else if (if_req && starve < STARVE_MAX) starve++;
`else
                exp_me = me_req;
`endif
                if (mem_req) begin
                    chk("grant_to_me", !mem_addr[12], exp_me);
                    if (exp_me) begin
                        chk("me_mem_addr",  mem_addr,  me_txn_addr);
                        chk("me_mem_wr",    mem_wr,    me_txn_wr);
                        chk("me_mem_wdata", mem_wdata, me_txn_wdata);
                        chk("me_mem_wmask", mem_wmask, me_txn_wmask);
                    end else begin
                        chk("if_mem_addr",  mem_addr,  if_txn_addr);
                        chk("if_mem_wr",    mem_wr,    0);
                        chk("if_mem_wmask", mem_wmask, 0);
                    end
                end
            end
            chk("pause_if", pause_if, if_req & ~if_ack);
            chk("pause_me", pause_me, me_req & ~me_ack);
            prev_req      = mem_req;
            prev_ack      = if_ack | me_ack;
            prev_me_owner = !mem_addr[12];
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        for (int i = 0; i < 64; i++) begin
            mem_arr[i] = 32'(i) * 32'h01010101 ^ 32'h13579BDF;
            ref_mem[i] = 32'(i) * 32'h01010101 ^ 32'h13579BDF;
        end
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        me_req    = 1'b0;
        me_wr     = 1'b0;
        me_wmask  = '0;
        me_addr   = '0;
        me_wdata  = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        stall     = 1'b0;
        armed     = 1'b0;
        me_last   = '0;
        me_ack_cnt      = 0;
        first_if_me_cnt = -1;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        #1 rst = 1'b1;

        // Random contention between both requesters
        fork
            if_run(40, 3);
            me_run(40, 3);
        join
        repeat (4) @(negedge clk);
        #1;

        // Reset asserted while IF access waits on the memory
        stall       = 1'b1;
        if_addr     = 32'h0000_1100;
        if_req      = 1'b1;
        if_txn_addr = if_addr;
        if_exp_q.push_back(if_word(if_addr));
        begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (mem_req) begin
                    got = 1'b1;
                    break;
                end
            end
            chk("rst_test_grant", got, 1);
        end
        #2 rst = 1'b0;
        #1;
        chk("async_rst_mem_req", mem_req, 0);
        chk("async_rst_if_ack",  if_ack, 0);
        @(negedge clk);
        #2;
        rst     = 1'b1;
        stall   = 1'b0;
        me_last = '0;
        wait_if_ack();
        if_req = 1'b0;
        repeat (3) @(negedge clk);
        #1;

        // Both requests held continuously: starvation behaviour
        apply_reset();
        me_ack_cnt      = 0;
        first_if_me_cnt = -1;
        armed           = 1'b1;
        fork
            if_run(1, 0);
            me_run(10, 0);
        join
        chk("me_acks_before_first_if", first_if_me_cnt, EXP_ME_BEFORE_IF);
        repeat (4) @(negedge clk);

        chk("if_queue_drained", if_exp_q.size(), 0);
        chk("me_queue_drained", me_exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
